// File: rtl/multdiv_param.sv
// multdiv_param: HI/LO multiply/divide unit with configurable latency.
// Supports mult/multu/div/divu, the madd/msub accumulate family and mthi/mtlo.
// Results are computed at the accept edge and held pending. The pending
// result is committed to HI/LO when the latency counter expires.
module multdiv_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [CW-1:0] MLAT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DLAT = CW'(DIV_LAT);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  // Divide via magnitudes so that MIN/-1 wraps to MIN with a zero remainder
  // and the remainder takes the dividend's sign. A zero divisor is replaced
  // by one only to keep the datapath defined; that result is never committed.
  // Returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] divrem(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic             na, nb;
    logic [WIDTH-1:0] ua, ub, uq, ur;
    na = sgn & a[WIDTH-1];
    nb = sgn & b[WIDTH-1];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    if (ub == '0) ub = WIDTH'(1);
    uq = ua / ub;
    ur = ua % ub;
    return {(na ? -ur : ur), ((na ^ nb) ? -uq : uq)};
  endfunction

  logic                   busy_q, busy_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]     pend_q, pend_d;
  logic                   pwr_q, pwr_d;

  logic                   accept;
  logic signed [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0]     uprod;
  logic [2*WIDTH-1:0]     acc;

  assign accept = start & ~cancel & ~busy_q & (op >= OP_MULT) & (op <= OP_MTLO);
  assign sprod  = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val}) *
                  $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
  assign uprod  = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
  assign acc    = {hi_q, lo_q};

  // Next state: count down an in-flight op and commit on expiry, else accept a new op.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    pwr_d  = pwr_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        if (pwr_q) {hi_d, lo_d} = pend_q;
      end
    end else if (accept) begin
      case (op)
        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          busy_d = 1'b1;
          cnt_d  = MLAT;
          pwr_d  = 1'b1;
          case (op)
            OP_MULT:  pend_d = sprod;
            OP_MULTU: pend_d = uprod;
            OP_MADD:  pend_d = acc + sprod;
            OP_MADDU: pend_d = acc + uprod;
            OP_MSUB:  pend_d = acc - sprod;
            default:  pend_d = acc - uprod;
          endcase
        end
        OP_DIV, OP_DIVU: begin
          busy_d = 1'b1;
          cnt_d  = DLAT;
          pwr_d  = (rt_val != '0);
          pend_d = divrem(rs_val, rt_val, op == OP_DIV);
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  // State registers; async reset discards any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
      pwr_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      pwr_q  <= pwr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_param.sv
// Bench for multdiv_param: directed vector table, hand-written corner
// sequences and randomized ops checked against a transaction-level model.
module tb_multdiv_param;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk, reset, start, cancel, busy;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;

  multdiv_param #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model architectural state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          cncl;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: new HI/LO and busy length for one issue.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input bit c, inout logic [31:0] h, inout logic [31:0] l,
                                output int lat);
    longint      sp, q, r;
    logic [63:0] up, acc;
    lat = 0;
    if (c || o == 0 || o > 10) return;
    sp  = longint'(int'(a)) * longint'(int'(b));
    up  = {32'd0, a} * {32'd0, b};
    acc = {h, l};
    case (o)
      1: begin {h, l} = sp;             lat = MULT_LAT; end
      2: begin {h, l} = up;             lat = MULT_LAT; end
      5: begin {h, l} = acc + 64'(sp); lat = MULT_LAT; end
      6: begin {h, l} = acc + up;       lat = MULT_LAT; end
      7: begin {h, l} = acc - 64'(sp); lat = MULT_LAT; end
      8: begin {h, l} = acc - up;       lat = MULT_LAT; end
      3: begin
        lat = DIV_LAT;
        if (b != 0) begin
          q = longint'(int'(a)) / longint'(int'(b));
          r = longint'(int'(a)) % longint'(int'(b));
          l = q[31:0];
          h = r[31:0];
        end
      end
      4: begin
        lat = DIV_LAT;
        if (b != 0) begin
          l = a / b;
          h = a % b;
        end
      end
      9:  h = a;
      10: l = a;
      default: ;
    endcase
  endfunction

  // Issue one op and wait (bounded) for busy to drop; optional mid-flight disturbances.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit c, input bit mid_cancel, input bit mid_mtlo,
                       output int cyc, output logic [31:0] h, output logic [31:0] l,
                       output bit stable);
    logic [31:0] h0, l0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c;
    @(negedge clk);
    start = 1'b0; op = 4'd0; cancel = 1'b0;
    h0 = hi; l0 = lo;
    cyc = 0;
    stable = 1'b1;
    while (busy && cyc < 200) begin
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      if (cyc == 2 && mid_cancel) cancel = 1'b1;
      if (cyc == 2 && mid_mtlo) begin
        start = 1'b1; op = 4'd10; rs_val = 32'h1234;
      end
      cyc++;
      @(negedge clk);
      cancel = 1'b0; start = 1'b0; op = 4'd0;
    end
    h = hi; l = lo;
  endtask

  vec_t        vt[16];
  int          cyc, mlat;
  logic [31:0] h, l, a, b;
  logic [3:0]  o;
  bit          c, stable;

  initial begin
    vt[0]  = '{"mult_neg",      4'd1,  32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vt[1]  = '{"multu_max",     4'd2,  32'hFFFFFFFF, 32'd2,        1'b0, 32'd1,        32'hFFFFFFFE, 5};
    vt[2]  = '{"madd_carry",    4'd5,  32'd1,        32'd1,        1'b0, 32'd1,        32'hFFFFFFFF, 5};
    vt[3]  = '{"msubu",         4'd8,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        32'd0,        5};
    vt[4]  = '{"div_neg",       4'd3,  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[5]  = '{"div_min_m1",    4'd3,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 10};
    vt[6]  = '{"mthi",          4'd9,  32'd5,        32'd0,        1'b0, 32'd5,        32'h80000000, 0};
    vt[7]  = '{"mtlo",          4'd10, 32'd9,        32'd0,        1'b0, 32'd5,        32'd9,        0};
    vt[8]  = '{"divu_by_zero",  4'd4,  32'd7,        32'd0,        1'b0, 32'd5,        32'd9,        10};
    vt[9]  = '{"mult_cancel",   4'd1,  32'd3,        32'd3,        1'b1, 32'd5,        32'd9,        0};
    vt[10] = '{"op_none",       4'd0,  32'd3,        32'd3,        1'b0, 32'd5,        32'd9,        0};
    vt[11] = '{"op_12",         4'd12, 32'd3,        32'd3,        1'b0, 32'd5,        32'd9,        0};
    vt[12] = '{"maddu_wrap",    4'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd3,        32'hA,        5};
    vt[13] = '{"msub",          4'd7,  32'd2,        32'd3,        1'b0, 32'd3,        32'd4,        5};
    vt[14] = '{"divu",          4'd4,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14,       10};
    vt[15] = '{"div_neg_dvsr",  4'd3,  32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,        32'hFFFFFFFD, 10};

    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vt[i].op, vt[i].rs, vt[i].rt, vt[i].cncl, 1'b0, 1'b0, cyc, h, l, stable);
      model(vt[i].op, vt[i].rs, vt[i].rt, vt[i].cncl, m_hi, m_lo, mlat);
      check({vt[i].name, "_busy"},   64'(cyc),    64'(vt[i].exp_cyc));
      check({vt[i].name, "_hi"},     64'(h),      64'(vt[i].exp_hi));
      check({vt[i].name, "_lo"},     64'(l),      64'(vt[i].exp_lo));
      check({vt[i].name, "_stable"}, 64'(stable), 64'd1);
    end

    // Cancel asserted while a div is in flight must not disturb it.
    do_op(4'd3, 32'd20, 32'd3, 1'b0, 1'b1, 1'b0, cyc, h, l, stable);
    model(4'd3, 32'd20, 32'd3, 1'b0, m_hi, m_lo, mlat);
    check("midcancel_busy", 64'(cyc), 64'd10);
    check("midcancel_hi",   64'(h),   64'd2);
    check("midcancel_lo",   64'(l),   64'd6);

    // mtlo pulsed during a mult is ignored.
    do_op(4'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, cyc, h, l, stable);
    model(4'd1, 32'd3, 32'd4, 1'b0, m_hi, m_lo, mlat);
    check("busyissue_busy",   64'(cyc),    64'd5);
    check("busyissue_hi",     64'(h),      64'd0);
    check("busyissue_lo",     64'(l),      64'd12);
    check("busyissue_stable", 64'(stable), 64'd1);

    // Randomized ops against the model.
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      c = ($urandom_range(0, 9) == 0);
      do_op(o, a, b, c, 1'b0, 1'b0, cyc, h, l, stable);
      model(o, a, b, c, m_hi, m_lo, mlat);
      check($sformatf("rand%0d_op%0d_busy", i, o), 64'(cyc), 64'(mlat));
      check($sformatf("rand%0d_op%0d_hi", i, o),   64'(h),   64'(m_hi));
      check($sformatf("rand%0d_op%0d_lo", i, o),   64'(l),   64'(m_lo));
    end

    // Async reset three cycles into a div, off the clock edge.
    @(negedge clk);
    start = 1'b1; op = 4'd4; rs_val = 32'd100; rt_val = 32'd7; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_hi",   64'(hi),   64'd0);
    check("async_lo",   64'(lo),   64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stable = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stable = 1'b0;
    end
    check("async_no_late_write", 64'(stable), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
